// File: rtl/perceptron_pkg.sv
// Shared types and sample-word layout for the perceptron sample sequencer.
// A sample word is {t, x2, x1}, with t in the MSB.
package perceptron_pkg;

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_DONE} seq_state_e;

  localparam int DATA_W_DEF = 8;
  localparam int SAMPLE_W   = 2*DATA_W_DEF + 1;

  function automatic int x1_ofs(int dw);
    return 0;
  endfunction

  function automatic int x2_ofs(int dw);
    return dw;
  endfunction

  function automatic int t_ofs(int dw);
    return 2*dw;
  endfunction

endpackage

// File: rtl/perceptron_sample_sequencer_if.sv
// Sample RAM read port: the sequencer is the master and the RAM is the slave.
// Read data is valid the cycle after mem_rd_en.
interface perceptron_sample_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [2*DATA_W:0] mem_rdata;

  modport master (output mem_rd_en, output mem_addr, input  mem_rdata);
  modport slave  (input  mem_rd_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/seq_epoch_counter.sv
// Sample pointer with modulo-n wrap, plus a saturating epoch counter.
// The count n is captured when clr is asserted.
module seq_epoch_counter #(
  parameter int ADDR_W  = 6,
  parameter int EPOCH_W = 8
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  input  logic [ADDR_W:0]    n_in,
  output logic [ADDR_W-1:0]  ptr,
  output logic [EPOCH_W-1:0] epoch,
  output logic               wrap
);
  logic [ADDR_W:0]    n_q, n_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  assign wrap  = adv && ({1'b0, ptr_q} == n_q - (ADDR_W+1)'(1));
  assign ptr   = ptr_q;
  assign epoch = epoch_q;

  always_comb begin
    n_d     = n_q;
    ptr_d   = ptr_q;
    epoch_d = epoch_q;
    if (clr) begin
      n_d     = n_in;
      ptr_d   = '0;
      epoch_d = '0;
    end else if (adv) begin
      ptr_d = wrap ? '0 : ptr_q + ADDR_W'(1);
      if (wrap && epoch_q != '1) epoch_d = epoch_q + EPOCH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q     <= '0;
      ptr_q   <= '0;
      epoch_q <= '0;
    end else begin
      n_q     <= n_d;
      ptr_q   <= ptr_d;
      epoch_q <= epoch_d;
    end
  end
endmodule

// File: rtl/perceptron_sample_sequencer.sv
// Feeds samples from the sample RAM to the perceptron trainer and sequences runs.
// Define SEQ_EPOCH_LIMIT_EN to end a run with timeout after MAX_EPOCHS epochs.
module perceptron_sample_sequencer
  import perceptron_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int EPOCH_W    = 8,
  parameter int MAX_EPOCHS = 100
)(
  input  logic                 clk,
  input  logic                 rst,
  perceptron_sample_sequencer_if.master mem,
  input  logic                 go,
  input  logic [ADDR_W:0]      n_samples,
  output logic                 start,
  input  logic                 ready_to_get_data,
  input  logic                 train_done,
  output logic [DATA_W-1:0]    x1,
  output logic [DATA_W-1:0]    x2,
  output logic                 t,
  output logic                 busy,
  output logic                 finished,
  output logic                 timeout,
  output logic [EPOCH_W-1:0]   epoch_cnt
);
  localparam int              SW    = t_ofs(DATA_W) + 1;
  localparam logic [ADDR_W:0] N_MAX = {1'b1, {ADDR_W{1'b0}}};

  seq_state_e        state_q, state_d;
  logic              start_q, start_d, busy_q, busy_d, fin_q, fin_d;
  logic              timeout_q, timeout_d;
  logic              rd_valid_q, rd_valid_d;
  logic [SW-1:0]     sample_q, sample_d, word;
  logic              rd, accept, wrap, limit_hit;
  logic [ADDR_W-1:0] ptr;

  assign accept = (state_q == S_IDLE) && go && (n_samples != '0) && (n_samples <= N_MAX);
  assign rd     = (state_q == S_KICK) || ((state_q == S_RUN) && ready_to_get_data);

  seq_epoch_counter #(.ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .adv   (rd),
    .n_in  (n_samples),
    .ptr   (ptr),
    .epoch (epoch_cnt),
    .wrap  (wrap)
  );

`ifdef SEQ_EPOCH_LIMIT_EN
  // The wrap that reaches the limit still issues its read; only the state is forced.
  assign limit_hit = wrap && (({1'b0, epoch_cnt} + (EPOCH_W+1)'(1)) == (EPOCH_W+1)'(MAX_EPOCHS));
`else
  logic unused_max;
  assign unused_max = ^MAX_EPOCHS;
  assign limit_hit  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d   = S_KICK;
        timeout_d = 1'b0;
      end
      S_KICK:  state_d = limit_hit ? S_DONE : S_RUN;
      S_RUN:   if (train_done || limit_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (limit_hit) timeout_d = 1'b1;
    start_d    = (state_d == S_KICK);
    busy_d     = (state_d != S_IDLE);
    fin_d      = (state_d == S_DONE);
    rd_valid_d = rd;
    sample_d   = rd_valid_q ? mem.mem_rdata : sample_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      timeout_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      fin_q      <= fin_d;
      timeout_q  <= timeout_d;
      rd_valid_q <= rd_valid_d;
      sample_q   <= sample_d;
    end
  end

  // Bypass so a fresh read reaches the trainer in the same cycle it returns.
  assign word          = rd_valid_q ? mem.mem_rdata : sample_q;
  assign x1            = word[x1_ofs(DATA_W) +: DATA_W];
  assign x2            = word[x2_ofs(DATA_W) +: DATA_W];
  assign t             = word[t_ofs(DATA_W)];
  assign mem.mem_rd_en = rd;
  assign mem.mem_addr  = ptr;
  assign start         = start_q;
  assign busy          = busy_q;
  assign finished      = fin_q;
  assign timeout       = timeout_q;
endmodule

// File: tb/tb_perceptron_sample_sequencer.sv
// Directed bench for perceptron_sample_sequencer: a behavioural model is compared
// every cycle, plus hand-computed literal checks at key points.
module tb_perceptron_sample_sequencer;
  localparam int DW = 8, AW = 6, EW = 8, MAXE = 2;

  logic          clk = 1'b0, rst = 1'b1, go = 1'b0, ready = 1'b0, tdone = 1'b0;
  logic [AW:0]   n_samples = '0;
  logic          start, t, busy, finished, timeout;
  logic [DW-1:0] x1, x2;
  logic [EW-1:0] epoch_cnt;
  int            errs = 0, checks = 0;
  bit            chk_en = 1'b0;

  perceptron_sample_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) mif();

  perceptron_sample_sequencer #(.DATA_W(DW), .ADDR_W(AW), .EPOCH_W(EW), .MAX_EPOCHS(MAXE)) dut (
    .clk(clk), .rst(rst), .mem(mif.master), .go(go), .n_samples(n_samples),
    .start(start), .ready_to_get_data(ready), .train_done(tdone),
    .x1(x1), .x2(x2), .t(t), .busy(busy), .finished(finished),
    .timeout(timeout), .epoch_cnt(epoch_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous sample RAM
  logic [2*DW:0] ram [0:63];
  always @(posedge clk) if (mif.mem_rd_en) mif.mem_rdata <= ram[mif.mem_addr];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 kick, 2 run, 3 done; m_cur is the last sample read.
  int            ph = 0, m_n = 1, m_ptr = 0, m_epoch = 0;
  bit            m_to = 1'b0;
  logic [2*DW:0] m_cur = '0;

  function automatic bit m_rd();
    return (ph == 1) || (ph == 2 && ready);
  endfunction

  always @(posedge clk) begin
    bit rd;
    rd = m_rd();
    if (rst) begin
      ph = 0; m_ptr = 0; m_epoch = 0; m_to = 1'b0; m_cur = '0;
    end else begin
      if (rd) m_cur = ram[m_ptr];
      case (ph)
        0: if (go && n_samples >= 1 && n_samples <= 64) begin
             m_n = int'(n_samples); m_ptr = 0; m_epoch = 0; m_to = 1'b0; ph = 1;
           end
        1: ph = 2;
        2: if (tdone) ph = 3;
        default: ph = 0;
      endcase
      if (rd) begin
        m_ptr++;
        if (m_ptr == m_n) begin
          m_ptr = 0;
          if (m_epoch < 255) m_epoch++;
`ifdef SEQ_EPOCH_LIMIT_EN
          if (m_epoch == MAXE) begin ph = 3; m_to = 1'b1; end
`endif
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("start",    start,         ph == 1);
    chk("busy",     busy,          ph != 0);
    chk("finished", finished,      ph == 3);
    chk("timeout",  timeout,       m_to);
    chk("epoch",    epoch_cnt,     m_epoch);
    chk("rd_en",    mif.mem_rd_en, m_rd());
    chk("addr",     mif.mem_addr,  m_ptr);
    chk("x1",       x1,            m_cur[7:0]);
    chk("x2",       x2,            m_cur[15:8]);
    chk("t",        t,             m_cur[16]);
  end

  task automatic cyc(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  logic [7:0] x1tab [4] = '{8'd5, 8'd7, 8'd0, 8'hFF};
  logic [7:0] x2tab [4] = '{8'd3, 8'hFE, 8'd0, 8'd1};
  logic       ttab  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int         fin_cnt;

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    for (int i = 0; i < 4; i++) ram[i] = {ttab[i], x2tab[i], x1tab[i]};
    cyc(2);
    chk_en = 1'b1;
    rst = 1'b0;
    chk("rst_start", start, 0); chk("rst_busy", busy, 0); chk("rst_x1", x1, 0);
    chk("rst_epoch", epoch_cnt, 0); chk("rst_addr", mif.mem_addr, 0);

    // n=4, one request every 3 cycles, wrap back to sample 0
    go = 1'b1; n_samples = 7'd4; cyc(1); go = 1'b0;
    chk("t1_start", start, 1); chk("t1_rd", mif.mem_rd_en, 1);
    cyc(1);
    chk("t1_x1_0", x1, 8'd5); chk("t1_x2_0", x2, 8'd3); chk("t1_t_0", t, 1);
    chk("model_x1_0", m_cur[7:0], 8'd5);
    for (int k = 0; k < 4; k++) begin
      ready = 1'b1; cyc(1); ready = 1'b0;
      chk("t1_x1", x1, x1tab[(k+1)%4]); chk("t1_x2", x2, x2tab[(k+1)%4]); chk("t1_t", t, ttab[(k+1)%4]);
      cyc(2);
    end
    chk("t1_epoch", epoch_cnt, 1);
    tdone = 1'b1; cyc(1); tdone = 1'b0;
    chk("t1_fin", finished, 1);
    cyc(1);
    chk("t1_fin_drop", finished, 0); chk("t1_busy_drop", busy, 0);
    go = 1'b1; n_samples = 7'd0; cyc(1); go = 1'b0;
    chk("t1_n0_busy", busy, 0); chk("t1_n0_start", start, 0);

    // n=3, back-to-back requests
    go = 1'b1; n_samples = 7'd3; cyc(1); go = 1'b0;
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      ready = 1'b1; #1;
      chk("t2_addr", mif.mem_addr, (i+1)%3);
      chk("t2_x1", x1, x1tab[i%3]);
      if (i == 5) chk("t2_epoch6", epoch_cnt, 2);
      cyc(1);
    end
    ready = 1'b0;
    go = 1'b1; n_samples = 7'd2; cyc(1); go = 1'b0;
    chk("t2_go_start", start, 0); chk("t2_go_epoch", epoch_cnt, 3); chk("t2_go_addr", mif.mem_addr, 0);
    tdone = 1'b1; cyc(1); tdone = 1'b0; cyc(2);

    // reset while a read is in flight
    go = 1'b1; n_samples = 7'd4; cyc(1); go = 1'b0;
    cyc(1);
    ready = 1'b1; cyc(1); ready = 1'b0;
    rst = 1'b1;
    chk("t3_bypass", x1, 8'd7);
    cyc(1); rst = 1'b0;
    chk("t3_x1", x1, 0); chk("t3_x2", x2, 0); chk("t3_t", t, 0);
    chk("t3_busy", busy, 0); chk("t3_addr", mif.mem_addr, 0);
    cyc(1);
    chk("t3_hold", x1, 0);
    go = 1'b1; n_samples = 7'd4; cyc(1); go = 1'b0;
    chk("t3_restart", start, 1); chk("t3_addr0", mif.mem_addr, 0);
    cyc(1);
    chk("t3_x1_0", x1, 8'd5);
    tdone = 1'b1; cyc(1); tdone = 1'b0; cyc(2);

    // n=2, continuous requests, no train_done
    go = 1'b1; n_samples = 7'd2; ready = 1'b1; cyc(1); go = 1'b0;
    fin_cnt = 0;
    for (int i = 0; i < 8; i++) begin cyc(1); fin_cnt += int'(finished); end
    ready = 1'b0;
`ifdef SEQ_EPOCH_LIMIT_EN
    chk("t4_timeout", timeout, 1); chk("t4_fin", fin_cnt, 1);
    chk("t4_epoch", epoch_cnt, 2); chk("t4_busy", busy, 0);
`else
    chk("t4_timeout", timeout, 0); chk("t4_fin", fin_cnt, 0);
    chk("t4_epoch", epoch_cnt, 4); chk("t4_busy", busy, 1);
`endif
    tdone = 1'b1; cyc(1); tdone = 1'b0; cyc(2);
    go = 1'b1; n_samples = 7'd1; cyc(1); go = 1'b0;
    chk("t4_to_clr", timeout, 0);
    tdone = 1'b1; cyc(2); tdone = 1'b0; cyc(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/perceptron_sample_sequencer.md
# perceptron_sample_sequencer

Feeds training samples from a synchronous sample RAM into the perceptron training controller and datapath, and sequences whole training runs. It kicks the trainer with a one-cycle `start`, then serves one sample per `ready_to_get_data` request in circular order. It counts epochs and reports completion or epoch-limit timeout to the host. It sits between the host/testbench, the sample RAM and the training control unit.

## Interface
- `DATA_W`, 8: width of each input feature x1, x2 (two's complement)
- `ADDR_W`, 6: sample RAM address width (up to 64 samples)
- `EPOCH_W`, 8: epoch counter width
- `MAX_EPOCHS`, 100: epoch limit, used only with `SEQ_EPOCH_LIMIT_EN`

Ports:
- `clk`, in, 1: single clock, rising edge
- `rst`, in, 1: synchronous, active-high reset
- `go`, in, 1: start a training run (pulse); ignored unless IDLE
- `n_samples`, in, ADDR_W+1: samples per epoch, captured on accepted `go`
- `mem_rd_en`, out, 1: RAM read strobe (combinational)
- `mem_addr`, out, ADDR_W: RAM read address (registered pointer)
- `mem_rdata`, in, 2*DATA_W+1: {t, x2, x1}, valid the cycle after `mem_rd_en`
- `start`, out, 1: one-cycle kick to the training controller
- `ready_to_get_data`, in, 1: trainer requests the next sample
- `train_done`, in, 1: trainer's done pulse
- `x1`, `x2`, out, DATA_W: current sample features
- `t`, out, 1: target (1 = +1, 0 = −1)
- `busy`, out, 1: run in progress
- `finished`, out, 1: one-cycle pulse at end of run
- `timeout`, out, 1: run ended by epoch limit; held until next accepted `go` or `rst`
- `epoch_cnt`, out, EPOCH_W: completed epochs in current/last run

## Operation
- States: IDLE → KICK → RUN → DONE → IDLE.
- IDLE: `go` with `n_samples` in 1..2^ADDR_W captures n, clears ptr, `epoch_cnt` and `timeout`, and moves to KICK. `go` with `n_samples`==0 or >2^ADDR_W is ignored.
- KICK (1 cycle): `start`=1, `mem_rd_en`=1 at `mem_addr`=0, ptr advances. Next state is RUN.
- RUN: `mem_rd_en` = `ready_to_get_data`, with `mem_addr` = ptr. On each read, ptr advances; ptr wraps from n−1 to 0, and each wrap increments `epoch_cnt` (saturating at all-ones). `train_done` → DONE.
- DONE (1 cycle): `finished`=1 → IDLE.
- Sample path: `rd_valid` is `mem_rd_en` delayed one cycle. `sample_q` loads `mem_rdata` when `rd_valid`=1. Outputs {t,x2,x1} = `rd_valid` ? `mem_rdata` : `sample_q` (same-cycle bypass).
- `busy` = state ≠ IDLE.
- `ready_to_get_data` and `train_done` outside RUN are ignored. `go` outside IDLE is ignored.
- Simultaneous `train_done` and `ready_to_get_data` in RUN: the read is still issued and counted, and the state goes to DONE.
- `rst` at any time: IDLE, ptr=0, `sample_q`=0, all outputs 0. An in-flight read is discarded (`rd_valid` cleared).

## Timing
- `go` accepted at edge E0 → `start` and `mem_rd_en` high in the cycle after E0. Sample 0 is on the outputs from the following cycle until the next read.
- Request in cycle C → new sample on `x1`/`x2`/`t` in C+1, stable until the next `rd_valid`. The trainer loads at the end of C+1.
- Throughput: one sample per cycle if requested back-to-back.
- `finished` is high in the cycle after `train_done` is sampled in RUN.
- Reset values: `start`=0, `mem_rd_en`=0, `mem_addr`=0, `x1`=`x2`=0, `t`=0, `busy`=0, `finished`=0, `timeout`=0, `epoch_cnt`=0.

## Configuration
- `SEQ_EPOCH_LIMIT_EN` defined:
  - A wrap that makes `epoch_cnt` == MAX_EPOCHS forces DONE and sets `timeout`.
  - That final read is still issued.
  - `finished` pulses as usual.
- `SEQ_EPOCH_LIMIT_EN` undefined:
  - No limit; `timeout` is tied to 0.
  - `MAX_EPOCHS` is unused.
  - The run ends only on `train_done` or `rst`.

## Structure
- Shared package `perceptron_pkg` holds:
  - state enum (IDLE, KICK, RUN, DONE)
  - `SAMPLE_W` = 2*DATA_W+1
  - field offset constants for t/x2/x1 within the sample word
- One sub-module, `seq_epoch_counter`:
  - ptr with modulo-n wrap
  - saturating epoch counter
  - `wrap` strobe output

## Test plan
- n=4, RAM {t,x2,x1} = {1,3,5},{0,−2,7},{1,0,0},{0,1,−1}, requests every 3 cycles → `start` one cycle after `go`; outputs step 5/3/1, 7/−2/0, 0/0/1, −1/1/0, then wrap to 5/3/1 with `epoch_cnt`=1.
- Back-to-back requests for 8 cycles with n=3 → addresses 1,2,0,1,2,0,…; each sample appears the cycle after its request; `epoch_cnt`=2 after 6 reads from start.
- `train_done` in RUN → `finished` pulses one cycle later, `busy` drops; a second `go` with n=0 → ignored, `busy` stays 0.
- `rst` asserted the cycle after a read is issued → next cycle all outputs 0, no sample update; a following `go` restarts from address 0.
- With `SEQ_EPOCH_LIMIT_EN`, MAX_EPOCHS=2, n=2, continuous requests and no `train_done` → `timeout`=1, `finished` pulse, `epoch_cnt`=2. Without the macro, the same stimulus keeps running with `timeout`=0.
- `go` pulsed during RUN → ignored: ptr, `epoch_cnt` and `start` unaffected.
